// File: rtl/data_mem_dumper_pkg.sv
// Shared definitions for the BIP debug-unit memory dumper: FSM state encoding
// and the address-width helper also used by data_mem.
package data_mem_dumper_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WAIT    = 3'd2,
        S_LATCH   = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5,
        S_NEXT    = 3'd6,
        S_DONE    = 3'd7
    } dump_state_e;

    // Number of bits needed to hold 'value'; data_mem sizes its address with clogb2(RAM_DEPTH-1).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    function automatic int bytes_per_word(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/data_mem_dumper_if.sv
// Memory read port, UART handshake and control signals of the dumper, grouped
// so the debug top level can pass them as one bundle.
interface data_mem_dumper_if #(
    parameter int RAM_WIDTH = 16,
    parameter int ADDR_W    = 10
);
    logic                 i_start;
    logic                 o_mem_sel;
    logic [ADDR_W-1:0]    o_mem_addr;
    logic [RAM_WIDTH-1:0] i_mem_data;
    logic [7:0]           o_tx_data;
    logic                 o_tx_start;
    logic                 i_tx_done;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        input  i_start, i_mem_data, i_tx_done,
        output o_mem_sel, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
    );

    modport slave (
        output i_start, i_mem_data, i_tx_done,
        input  o_mem_sel, o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface

// File: rtl/data_mem_dumper.sv
// Walks data_mem addresses 0..DUMP_WORDS-1 and streams every word to uart_tx
// as bytes, most significant byte first, using a start/done handshake.
module data_mem_dumper
    import data_mem_dumper_pkg::*;
#(
    parameter int RAM_WIDTH  = 16,
    parameter int RAM_DEPTH  = 1024,
    parameter int DUMP_WORDS = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    data_mem_dumper_if.master  bus
);

    localparam int ADDR_W = clogb2(RAM_DEPTH - 1);
    localparam int BYTES  = bytes_per_word(RAM_WIDTH);
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LAT_W  = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);

    dump_state_e          state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BIDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic [RAM_WIDTH-1:0] word_q, word_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 mem_sel_q, mem_sel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // NOTE: every register is reset, the word register included, so the
    // outputs and the next dump never depend on what was latched before reset.
    // NOTE: state registers use non-blocking assignment so all of them update
    // together from the values computed before the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            byte_idx_q <= '0;
            lat_cnt_q  <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            mem_sel_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            lat_cnt_q  <= lat_cnt_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            mem_sel_q  <= mem_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        lat_cnt_d  = lat_cnt_q;
        word_d     = word_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        mem_sel_d  = mem_sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d   = S_ADDR;
                    mem_sel_d = 1'b1;
                    busy_d    = 1'b1;
                    addr_d    = '0;
                end
            end
            S_ADDR: begin
                state_d   = S_WAIT;
                lat_cnt_d = LAT_W'(RD_LATENCY);
            end
            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                word_d     = bus.i_mem_data;
                byte_idx_d = BIDX_W'(BYTES - 1);
                state_d    = S_SEND;
            end
            S_SEND: begin
                tx_data_d  = word_q[byte_idx_q*BYTE_W +: BYTE_W];
                tx_start_d = 1'b1;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                // tx_data_q is left alone here so the byte stays stable for uart_tx.
                if (bus.i_tx_done) begin
                    if (byte_idx_q != '0) begin
                        byte_idx_d = byte_idx_q - BIDX_W'(1);
                        state_d    = S_SEND;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                mem_sel_d = 1'b0;
                addr_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_mem_sel  = mem_sel_q;
    assign bus.o_mem_addr = addr_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule

// File: tb/tb_data_mem_dumper.sv
// Directed bench: three dumper instances (2 words / full depth / 2-cycle read)
// against a shared data_mem model and uart_tx stubs answering 5 cycles after start.
module tb_data_mem_dumper;
    import data_mem_dumper_pkg::*;

    localparam int RW = 16;
    localparam int RD = 1024;
    localparam int AW = clogb2(RD - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    data_mem_dumper_if #(.RAM_WIDTH(RW), .ADDR_W(AW)) if_a ();
    data_mem_dumper_if #(.RAM_WIDTH(RW), .ADDR_W(AW)) if_b ();
    data_mem_dumper_if #(.RAM_WIDTH(RW), .ADDR_W(AW)) if_c ();

    data_mem_dumper #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .DUMP_WORDS(2), .RD_LATENCY(1))
        u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a));
    data_mem_dumper #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .DUMP_WORDS(RD), .RD_LATENCY(1))
        u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b));
    data_mem_dumper #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .DUMP_WORDS(2), .RD_LATENCY(2))
        u_dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c));

    // data_mem models: one registered stage for a/b, two registered stages for c
    logic [RW-1:0] mem [RD];
    logic [RW-1:0] c_stage;
    always @(posedge clk) begin
        if_a.i_mem_data <= mem[if_a.o_mem_addr];
        if_b.i_mem_data <= mem[if_b.o_mem_addr];
        c_stage         <= mem[if_c.o_mem_addr];
        if_c.i_mem_data <= c_stage;
    end

    // uart_tx stubs: i_tx_done 5 cycles after o_tx_start; a's can be stretched or injected
    logic [5:0] sr_a;
    logic [4:0] sr_b, sr_c;
    logic stretch_a = 1'b0;
    logic inject_a = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_a <= '0;
            sr_b <= '0;
            sr_c <= '0;
        end else begin
            sr_a <= {sr_a[4:0], if_a.o_tx_start};
            sr_b <= {sr_b[3:0], if_b.o_tx_start};
            sr_c <= {sr_c[3:0], if_c.o_tx_start};
        end
    end
    assign if_a.i_tx_done = sr_a[4] | (stretch_a & sr_a[5]) | inject_a;
    assign if_b.i_tx_done = sr_b[4];
    assign if_c.i_tx_done = sr_c[4];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor a: byte capture, pulse width, data hold, handshake gaps, mem_sel
    logic [7:0] q_a[$];
    int base_a = 0;
    int done_cnt_a = 0;
    int wcnt_a = 0;
    int last_done_cyc_a = 0;
    int unstable_a = 0;
    int sel_bad_a = 0;
    int idx_a;
    logic pend_a = 1'b0;
    logic [7:0] held_a = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_a = 1'b0;
            wcnt_a = 0;
        end else begin
            if (if_a.o_tx_start) begin
                if (wcnt_a == 0) begin
                    idx_a = q_a.size() - base_a;
                    if (idx_a > 0)
                        check("tx_gap_a", 32'(cyc - last_done_cyc_a), (idx_a % 2 == 0) ? 32'd6 : 32'd2);
                    check("sel_at_start_a", 32'(if_a.o_mem_sel), 32'd1);
                    q_a.push_back(if_a.o_tx_data);
                    held_a     = if_a.o_tx_data;
                    pend_a     = 1'b1;
                    unstable_a = 0;
                end
                wcnt_a = wcnt_a + 1;
            end else if (wcnt_a != 0) begin
                check("start_width_a", 32'(wcnt_a), 32'd1);
                wcnt_a = 0;
            end
            if (pend_a && if_a.o_tx_data != held_a) unstable_a = 1;
            if (pend_a && if_a.i_tx_done) begin
                check("tx_hold_a", 32'(unstable_a), 32'd0);
                pend_a          = 1'b0;
                last_done_cyc_a = cyc;
            end
            if (if_a.o_done) done_cnt_a = done_cnt_a + 1;
            if (if_a.o_busy && !if_a.o_mem_sel) sel_bad_a = sel_bad_a + 1;
        end
    end

    // monitor b: full-depth dump, byte data against the memory image
    int start_cnt_b = 0;
    int done_cnt_b = 0;
    int bad_data_b = 0;
    int addr0_b = 0;
    logic prev_start_b = 1'b0;
    logic nz_b = 1'b0;
    logic [7:0] last2_b [2];
    logic [AW-1:0] last_addr_b = '0;
    logic [RW-1:0] w_b;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (if_b.o_tx_start && !prev_start_b) begin
            w_b   = mem[if_b.o_mem_addr];
            exp_b = (start_cnt_b % 2 == 0) ? w_b[15:8] : w_b[7:0];
            if (if_b.o_tx_data != exp_b) bad_data_b = bad_data_b + 1;
            last2_b[0]  = last2_b[1];
            last2_b[1]  = if_b.o_tx_data;
            last_addr_b = if_b.o_mem_addr;
            start_cnt_b = start_cnt_b + 1;
        end
        prev_start_b = if_b.o_tx_start;
        if (if_b.o_mem_addr != '0) nz_b = 1'b1;
        if (if_b.o_busy && nz_b && if_b.o_mem_addr == '0) addr0_b = addr0_b + 1;
        if (if_b.o_done) done_cnt_b = done_cnt_b + 1;
    end

    // monitor c: byte capture
    logic [7:0] q_c[$];
    int done_cnt_c = 0;
    logic prev_start_c = 1'b0;
    always @(negedge clk) begin
        if (if_c.o_tx_start && !prev_start_c) q_c.push_back(if_c.o_tx_data);
        prev_start_c = if_c.o_tx_start;
        if (if_c.o_done) done_cnt_c = done_cnt_c + 1;
    end

    function automatic int done_of(input int k);
        case (k)
            0:       return done_cnt_a;
            1:       return done_cnt_b;
            default: return done_cnt_c;
        endcase
    endfunction

    task automatic wait_done(input string tag, input int k, input int base, input int budget);
        int n;
        n = 0;
        while (done_of(k) == base && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check(tag, 32'(done_of(k) != base), 32'd1);
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        case (k)
            0:       if_a.i_start = 1'b1;
            1:       if_b.i_start = 1'b1;
            default: if_c.i_start = 1'b1;
        endcase
        @(negedge clk);
        if_a.i_start = 1'b0;
        if_b.i_start = 1'b0;
        if_c.i_start = 1'b0;
    endtask

    task automatic check_bytes_a(input string tag);
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h5A, 8'h12, 8'h34};
        check({tag, "_count"}, 32'(q_a.size() - base_a), 32'd4);
        for (int i = 0; i < 4; i++) check({tag, "_byte"}, 32'(q_a[base_a + i]), 32'(exp[i]));
    endtask

    int d0;
    int n;

    initial begin
        for (int i = 0; i < RD; i++) mem[i] = 16'(i * 16'h0137 + 16'h5A00);
        mem[0]    = 16'hA55A;
        mem[1]    = 16'h1234;
        mem[1023] = 16'hBEEF;
        if_a.i_start = 1'b0;
        if_b.i_start = 1'b0;
        if_c.i_start = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_sel_a",   32'(if_a.o_mem_sel),  32'd0);
        check("rst_busy_a",  32'(if_a.o_busy),     32'd0);
        check("rst_start_a", 32'(if_a.o_tx_start), 32'd0);
        check("rst_done_a",  32'(if_a.o_done),     32'd0);
        check("rst_data_a",  32'(if_a.o_tx_data),  32'd0);
        check("rst_addr_a",  32'(if_a.o_mem_addr), 32'd0);
        check("rst_outs_b", 32'({if_b.o_mem_sel, if_b.o_busy, if_b.o_tx_start, if_b.o_done,
                                 if_b.o_tx_data, if_b.o_mem_addr}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // two-word dump, MSB first
        base_a = q_a.size();
        d0 = done_cnt_a;
        pulse_start(0);
        check("t1_busy",  32'(if_a.o_busy),     32'd1);
        check("t1_sel",   32'(if_a.o_mem_sel),  32'd1);
        check("t1_addr0", 32'(if_a.o_mem_addr), 32'd0);
        wait_done("t1_done_seen", 0, d0, 2000);
        repeat (3) @(negedge clk);
        check_bytes_a("t1");
        check("t1_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        check("t1_busy_after",  32'(if_a.o_busy),     32'd0);
        check("t1_sel_after",   32'(if_a.o_mem_sel),  32'd0);
        check("t1_addr_after",  32'(if_a.o_mem_addr), 32'd0);

        // restarts while busy, stretched tx_done into SEND/NEXT, start in DONE cycle
        stretch_a = 1'b1;
        base_a = q_a.size();
        d0 = done_cnt_a;
        pulse_start(0);
        repeat (10) @(negedge clk);
        pulse_start(0);
        repeat (15) @(negedge clk);
        pulse_start(0);
        n = 0;
        while (!if_a.o_done && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t3_done_seen", 32'(if_a.o_done), 32'd1);
        if_a.i_start = 1'b1;
        @(negedge clk);
        if_a.i_start = 1'b0;
        repeat (20) @(negedge clk);
        stretch_a = 1'b0;
        check_bytes_a("t3");
        check("t3_done_pulses", 32'(done_cnt_a - d0), 32'd1);
        check("t3_busy_after",  32'(if_a.o_busy),     32'd0);
        inject_a = 1'b1;
        @(negedge clk);
        inject_a = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_idle_done_busy",  32'(if_a.o_busy),         32'd0);
        check("t3_idle_done_bytes", 32'(q_a.size() - base_a), 32'd4);

        // reset during WAIT_TX of byte 3, then a clean restart
        base_a = q_a.size();
        pulse_start(0);
        n = 0;
        while (q_a.size() - base_a < 3 && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t4_third_byte", 32'(q_a[base_a + 2]), 32'h12);
        rst_n = 1'b0;
        #1;
        check("t4_rst_sel",   32'(if_a.o_mem_sel),  32'd0);
        check("t4_rst_busy",  32'(if_a.o_busy),     32'd0);
        check("t4_rst_data",  32'(if_a.o_tx_data),  32'd0);
        check("t4_rst_addr",  32'(if_a.o_mem_addr), 32'd0);
        check("t4_rst_ctl",   32'({if_a.o_tx_start, if_a.o_done}), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        base_a = q_a.size();
        d0 = done_cnt_a;
        pulse_start(0);
        check("t4_restart_addr", 32'(if_a.o_mem_addr), 32'd0);
        n = 0;
        while (q_a.size() == base_a && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t4_first_byte", 32'(q_a[base_a]),     32'hA5);
        check("t4_first_addr", 32'(if_a.o_mem_addr), 32'd0);
        wait_done("t4_done_seen", 0, d0, 2000);
        repeat (3) @(negedge clk);
        check_bytes_a("t4");

        // full-depth dump up to the last address
        d0 = done_cnt_b;
        pulse_start(1);
        wait_done("t2_done_seen", 1, d0, 40000);
        repeat (3) @(negedge clk);
        check("t2_start_count", 32'(start_cnt_b), 32'd2048);
        check("t2_last_hi",     32'(last2_b[0]),  32'hBE);
        check("t2_last_lo",     32'(last2_b[1]),  32'hEF);
        check("t2_last_addr",   32'(last_addr_b), 32'd1023);
        check("t2_addr0_seen",  32'(addr0_b),     32'd0);
        check("t2_bad_data",    32'(bad_data_b),  32'd0);
        check("t2_done_pulses", 32'(done_cnt_b - d0), 32'd1);
        check("t2_busy_after",  32'(if_b.o_busy), 32'd0);

        // two-cycle read latency with a registered-output memory
        mem[0] = 16'h00FF;
        d0 = done_cnt_c;
        pulse_start(2);
        wait_done("t5_done_seen", 2, d0, 2000);
        repeat (3) @(negedge clk);
        check("t5_count", 32'(q_c.size()), 32'd4);
        check("t5_byte0", 32'(q_c[0]), 32'h00);
        check("t5_byte1", 32'(q_c[1]), 32'hFF);
        check("t5_byte2", 32'(q_c[2]), 32'h12);
        check("t5_byte3", 32'(q_c[3]), 32'h34);

        check("mem_sel_while_busy_a", 32'(sel_bad_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
